cache_ctrl: RTL and testbench



---
 rtl/cache_pkg.sv | 25 ++
 rtl/cache_store.sv | 73 +++++++
 rtl/cache_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_cache_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and block/byte helper for the direct-mapped
// write-back cache controller.
package cache_pkg;

    localparam int ADDR_W = 10;
    localparam int BLK_W  = 128;
    localparam int OFF_W  = 4;
    localparam int IDX_W  = 2;
    localparam int TAG_W  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_e;

    // Select byte 'off' out of a cache block.
    function automatic logic [BYTE_W-1:0] get_byte(input logic [BLK_W-1:0] blk,
                                                   input logic [OFF_W-1:0] off);
        return blk[{off, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/cache_store.sv
// Tag/valid/dirty/data storage: one asynchronous read port, one write port that
// either refills a whole block (valid, clean) or updates one byte (dirty).
module cache_store
    import cache_pkg::*;
#(
    parameter int LINES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [BLK_W-1:0]  rd_data,
    input  logic              wr_en,
    input  logic              wr_full,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [BYTE_W-1:0] wr_byte,
    input  logic [BLK_W-1:0]  wr_block
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [BLK_W-1:0] data_q [LINES];

    // Next valid/dirty bits: refill marks valid+clean, byte write marks dirty.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (wr_en) begin
            if (wr_full) begin
                valid_d[wr_idx] = 1'b1;
                dirty_d[wr_idx] = 1'b0;
            end else begin
                dirty_d[wr_idx] = 1'b1;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid/dirty state register; the only storage that reset clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays, deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_full) begin
                tag_q[wr_idx]  <= wr_tag;
                data_q[wr_idx] <= wr_block;
            end else begin
                data_q[wr_idx][{wr_off, 3'b000} +: BYTE_W] <= wr_byte;
            end
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache controller: latches one CPU byte request,
// looks it up, and writes back / refills blocks over a held request/ack bus.
module cache_ctrl #(
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int LINES  = 4,
    parameter int BLK_W  = cache_pkg::BLK_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BLK_W-1:0]  mem_wdata,
    input  logic [BLK_W-1:0]  mem_rdata,
    input  logic              mem_ack
);
    import cache_pkg::*;

    state_e              state_q, state_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                missed_q, missed_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic                cpu_hit_q, cpu_hit_d;
    logic [7:0]          cpu_rdata_q, cpu_rdata_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BLK_W-1:0]    mem_wdata_q, mem_wdata_d;

    logic [OFF_W-1:0]    off_s;
    logic [IDX_W-1:0]    idx_s;
    logic [TAG_W-1:0]    tag_s;
    logic                rd_valid_s, rd_dirty_s, hit_s;
    logic [TAG_W-1:0]    rd_tag_s;
    logic [BLK_W-1:0]    rd_data_s;
    logic                wr_en_s, wr_full_s;

    assign off_s = addr_q[OFF_W-1:0];
    assign idx_s = addr_q[OFF_W +: IDX_W];
    assign tag_s = addr_q[OFF_W+IDX_W +: TAG_W];
    assign hit_s = rd_valid_s && (rd_tag_s == tag_s);

    cache_store #(.LINES(LINES)) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (idx_s),
        .rd_valid (rd_valid_s),
        .rd_dirty (rd_dirty_s),
        .rd_tag   (rd_tag_s),
        .rd_data  (rd_data_s),
        .wr_en    (wr_en_s),
        .wr_full  (wr_full_s),
        .wr_idx   (idx_s),
        .wr_tag   (tag_s),
        .wr_off   (off_s),
        .wr_byte  (wdata_q),
        .wr_block (mem_rdata)
    );

    // Next-state and output logic; cpu_ready is registered, so a request
    // still held during the ready pulse must not be re-accepted.
    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        missed_d    = missed_q;
        cpu_ready_d = 1'b0;
        cpu_hit_d   = cpu_hit_q;
        cpu_rdata_d = cpu_rdata_q;
        mem_req_d   = mem_req_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_en_s     = 1'b0;
        wr_full_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req && !cpu_ready_q) begin
                    rw_d     = cpu_rw;
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    missed_d = 1'b0;
                    state_d  = COMPARE;
                end else begin
                    state_d  = IDLE;
                end
            end
            COMPARE: begin
                if (hit_s) begin
                    cpu_ready_d = 1'b1;
                    cpu_hit_d   = !missed_q;
                    state_d     = IDLE;
                    if (rw_q) begin
                        wr_en_s = 1'b1;
                    end else begin
                        cpu_rdata_d = get_byte(rd_data_s, off_s);
                    end
                end else begin
                    missed_d  = 1'b1;
                    mem_req_d = 1'b1;
                    if (rd_valid_s && rd_dirty_s) begin
                        state_d     = WRITEBACK;
                        mem_rw_d    = 1'b1;
                        mem_addr_d  = {rd_tag_s, idx_s, {OFF_W{1'b0}}};
                        mem_wdata_d = rd_data_s;
                    end else begin
                        state_d     = ALLOCATE;
                        mem_rw_d    = 1'b0;
                        mem_addr_d  = {tag_s, idx_s, {OFF_W{1'b0}}};
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack) begin
                    state_d    = ALLOCATE;
                    mem_rw_d   = 1'b0;
                    mem_addr_d = {tag_s, idx_s, {OFF_W{1'b0}}};
                end else begin
                    state_d    = WRITEBACK;
                end
            end
            ALLOCATE: begin
                if (mem_ack) begin
                    wr_en_s   = 1'b1;
                    wr_full_s = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = COMPARE;
                end else begin
                    state_d   = ALLOCATE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State, request latches and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            missed_q    <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_hit_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            mem_req_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            missed_q    <= missed_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_hit_q   <= cpu_hit_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_hit   = cpu_hit_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed scenarios plus a random stream checked against
// a byte-array view of memory and a line-level hit/miss/dirty model.
module tb_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req = 1'b0;
    logic         cpu_rw = 1'b0;
    logic [9:0]   cpu_addr = 10'h000;
    logic [7:0]   cpu_wdata = 8'h00;
    logic [7:0]   cpu_rdata;
    logic         cpu_ready, cpu_hit;
    logic         mem_req, mem_rw;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ack;
    logic         resp_ack = 1'b0;
    logic         stray_ack = 1'b0;

    assign mem_ack = resp_ack | stray_ack;

    cache_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_rw    (cpu_rw),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_hit   (cpu_hit),
        .mem_req   (mem_req),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] mem_bytes [1024];
    logic [7:0] gold      [1024];
    bit         m_valid [4];
    bit         m_dirty [4];
    int         m_tag   [4];
    int         wb_count = 0;
    int         alloc_count = 0;
    logic [7:0] last_rdata = 8'h00;

    int           resp_cnt = 0;
    bit           prev_req = 1'b0;
    bit           prev_ack = 1'b0;
    logic [9:0]   prev_addr = 10'h000;
    logic         prev_rw = 1'b0;
    logic [127:0] prev_wdata = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: byte i holds i[7:0]; ack three cycles after a request is seen.
    always @(negedge clk) begin
        if (!rst_n) begin
            resp_ack = 1'b0;
            resp_cnt = 0;
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (prev_req && !prev_ack) begin
                chk("mem_req_held", {127'd0, mem_req}, 128'd1);
                if (mem_req) begin
                    chk("mem_addr_stable", {118'd0, mem_addr}, {118'd0, prev_addr});
                    chk("mem_rw_stable", {127'd0, mem_rw}, {127'd0, prev_rw});
                    if (prev_rw) chk("mem_wdata_stable", mem_wdata, prev_wdata);
                end
            end
            prev_req   = mem_req;
            prev_addr  = mem_addr;
            prev_rw    = mem_rw;
            prev_wdata = mem_wdata;
            resp_ack   = 1'b0;
            if (mem_req) begin
                chk("mem_addr_aligned", {124'd0, mem_addr[3:0]}, 128'd0);
                resp_cnt++;
                if (resp_cnt == 3) begin
                    resp_cnt = 0;
                    resp_ack = 1'b1;
                    for (int i = 0; i < 16; i++) begin
                        if (mem_rw) mem_bytes[{mem_addr[9:4], 4'h0} + i] = mem_wdata[8*i +: 8];
                        else mem_rdata[8*i +: 8] = mem_bytes[{mem_addr[9:4], 4'h0} + i];
                    end
                    if (mem_rw) wb_count++;
                    else alloc_count++;
                end
            end else begin
                resp_cnt = 0;
            end
            prev_ack = resp_ack;
        end
    end

    // One CPU access with all checks derived from the reference model.
    task automatic access(input bit rw, input logic [9:0] a, input logic [7:0] wd, input string tag);
        int  idx, tg, wb0, al0, cyc;
        bit  exp_hit, exp_wb, got;
        idx = int'(a[5:4]);
        tg  = int'(a[9:6]);
        wb0 = wb_count;
        al0 = alloc_count;
        @(negedge clk);
        chk({tag, "/ready_low"}, {127'd0, cpu_ready}, 128'd0);
        chk({tag, "/rdata_hold"}, {120'd0, cpu_rdata}, {120'd0, last_rdata});
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb  = !exp_hit && m_valid[idx] && m_dirty[idx];
        cpu_req   = 1'b1;
        cpu_rw    = rw;
        cpu_addr  = a;
        cpu_wdata = wd;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            got = cpu_ready;
        end
        cpu_req = 1'b0;
        chk({tag, "/ready_seen"}, {127'd0, got}, 128'd1);
        chk({tag, "/hit"}, {127'd0, cpu_hit}, {127'd0, exp_hit});
        if (exp_hit) chk({tag, "/hit_latency"}, 128'(cyc), 128'd2);
        chk({tag, "/writebacks"}, 128'(wb_count - wb0), 128'(exp_wb));
        chk({tag, "/fills"}, 128'(alloc_count - al0), 128'(!exp_hit));
        if (!rw) begin
            chk({tag, "/rdata"}, {120'd0, cpu_rdata}, {120'd0, gold[a]});
            last_rdata = gold[a];
        end
        if (!exp_hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (rw) begin
            m_dirty[idx] = 1'b1;
            gold[a]      = wd;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/cpu_ready"}, {127'd0, cpu_ready}, 128'd0);
        chk({tag, "/cpu_hit"}, {127'd0, cpu_hit}, 128'd0);
        chk({tag, "/cpu_rdata"}, {120'd0, cpu_rdata}, 128'd0);
        chk({tag, "/mem_req"}, {127'd0, mem_req}, 128'd0);
        chk({tag, "/mem_rw"}, {127'd0, mem_rw}, 128'd0);
        chk({tag, "/mem_addr"}, {118'd0, mem_addr}, 128'd0);
        chk({tag, "/mem_wdata"}, mem_wdata, 128'd0);
    endtask

    initial begin
        int  wb_snap, waited;
        bit  rw;
        logic [9:0] a;
        for (int i = 0; i < 1024; i++) begin
            mem_bytes[i] = 8'(i);
            gold[i]      = 8'(i);
        end
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 0;
        end

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        access(1'b0, 10'h000, 8'h00, "cold_read");
        access(1'b1, 10'h000, 8'hFF, "write_hit");
        access(1'b0, 10'h000, 8'h00, "read_hit");
        chk("mem_byte0_before_wb", {120'd0, mem_bytes[0]}, 128'h00);

        access(1'b0, 10'h200, 8'h00, "dirty_evict");
        chk("mem_byte0_after_wb", {120'd0, mem_bytes[0]}, 128'hFF);

        wb_snap = wb_count;
        access(1'b0, 10'h000, 8'h00, "clean_miss_a");
        access(1'b0, 10'h300, 8'h00, "clean_miss_b");
        chk("no_wb_clean", 128'(wb_count), 128'(wb_snap));

        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        chk("stray_ack_no_req", {127'd0, mem_req}, 128'd0);
        access(1'b0, 10'h305, 8'h00, "after_stray_ack");

        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_rw   = 1'b0;
        cpu_addr = 10'h050;
        waited   = 0;
        while (!mem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("alloc_started", {127'd0, mem_req}, 128'd1);
        chk("alloc_is_read", {127'd0, mem_rw}, 128'd0);
        #2 rst_n = 1'b0;
        #1 chk("rst_drops_mem_req", {127'd0, mem_req}, 128'd0);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("mid_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 1024; i++) gold[i] = mem_bytes[i];
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        last_rdata = 8'h00;
        access(1'b0, 10'h010, 8'h00, "post_reset_read");

        for (int n = 0; n < 300; n++) begin
            rw = 1'($urandom_range(0, 1));
            a  = {4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            access(rw, a, 8'($urandom), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
